fmap_packer: RTL and testbench

- Producer side of the parallel feature-map interface consumed by the activation stage (`valid_in` + `data_in[0:LENGTH-1]`).
- Accepts one signed element per cycle from a serial valid/ready stream (conv/pool engine output, raster order) and assembles a full LENGTH-element map.
- On completion, presents the whole map in parallel with a one-cycle `valid_out` strobe.
- Output array is double-buffered, so it stays stable while the next map fills.

---
 rtl/fmap_packer.sv | 129 ++++++++++++
 tb/tb_fmap_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_packer.sv
// Serial-to-parallel feature-map packer: collects LENGTH stream beats and
// presents the completed map on a double-buffered output with a one-cycle strobe.
module fmap_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 676,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_last,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] data_out [0:LENGTH-1],
    output logic                         frame_err,
    output logic [CNT_WIDTH-1:0]         frame_count
);

    localparam int IDX_W = $clog2(LENGTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    typedef enum logic {
        FILL,
        DISCARD
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   fill_we;
    logic                   load_out;
    logic                   beat;

    logic signed [DATA_WIDTH-1:0] fill_q [0:LENGTH-2];
    logic signed [DATA_WIDTH-1:0] data_q [0:LENGTH-1];

    assign s_ready = !rst;
    assign beat    = s_valid && s_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // one unassigned and no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        fill_we  = 1'b0;
        load_out = 1'b0;
        if (beat) begin
            case (state_q)
                FILL: begin
                    if (idx_q == LAST_IDX) begin
                        // Final element completes the map whether or not s_last is set.
                        load_out = 1'b1;
                        valid_d  = 1'b1;
                        cnt_d    = cnt_q + CNT_WIDTH'(1);
                        idx_d    = '0;
                        if (!s_last) begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        fill_we = 1'b1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                DISCARD: begin
                    if (s_last) begin
                        state_d = FILL;
                        idx_d   = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the fill buffer has no reset; its contents are only read after
    // being rewritten by the current frame, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            fill_q[idx_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LENGTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (load_out) begin
            for (int i = 0; i < LENGTH - 1; i++) begin
                data_q[i] <= fill_q[i];
            end
            data_q[LENGTH-1] <= s_data;
        end
    end

    assign valid_out   = valid_q;
    assign frame_err   = err_q;
    assign frame_count = cnt_q;
    assign data_out    = data_q;

endmodule

// File: tb/tb_fmap_packer.sv
// Self-checking bench for fmap_packer: table of frame scenarios driven through a
// per-cycle step task, checked against a frame-position reference model.
module tb_fmap_packer;

    localparam int DW  = 8;
    localparam int LEN = 676;
    localparam int CW  = 16;
    localparam int NE  = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 s_last;
    logic                 valid_out;
    logic signed [DW-1:0] data_out [0:LEN-1];
    logic                 frame_err;
    logic [CW-1:0]        frame_count;

    always #5 clk = ~clk;

    fmap_packer #(.DATA_WIDTH(DW), .LENGTH(LEN), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    typedef enum {PAT_RAMP, PAT_FF, PAT_RAND} pat_t;

    typedef struct {
        int   n_beats;
        int   last_at;
        pat_t pat;
        bit   gaps;
        int   idle_after;
        bit   rst_after;
        int   exp_strobes;
        int   exp_errs;
    } vec_t;

    vec_t vecs [NE];

    int checks = 0;
    int errors = 0;

    // Reference model: position of the next beat within the current frame.
    bit                   armed = 1'b0;
    bit                   exp_v, exp_e;
    logic [CW-1:0]        exp_cnt;
    logic signed [DW-1:0] exp_out [0:LEN-1];
    logic signed [DW-1:0] cur [$];
    int                   pos;

    int                   cyc = 0;
    int                   cur_entry = 15;
    int                   prev_entry = 15;
    int                   obs_s [16];
    int                   obs_e [16];
    int                   strobe_cyc [$];
    logic signed [DW-1:0] first_beat [NE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_beat(input bit r, input bit v, input logic signed [DW-1:0] d, input bit l);
        if (r) begin
            armed   = 1'b1;
            exp_v   = 1'b0;
            exp_e   = 1'b0;
            exp_cnt = '0;
            pos     = 0;
            cur.delete();
            for (int i = 0; i < LEN; i++) exp_out[i] = '0;
            return;
        end
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (!armed || !v) return;
        if (pos >= LEN) begin
            if (l) pos = 0;
        end else begin
            cur.push_back(d);
            pos++;
            if (pos == LEN) begin
                for (int i = 0; i < LEN; i++) exp_out[i] = cur[i];
                cur.delete();
                exp_v   = 1'b1;
                exp_cnt = exp_cnt + 1'b1;
                if (l) pos = 0;
                else   exp_e = 1'b1;
            end else if (l) begin
                exp_e = 1'b1;
                pos   = 0;
                cur.delete();
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic signed [DW-1:0] d, input bit l);
        int bad;
        @(negedge clk);
        cyc++;
        check("s_ready", 32'(s_ready), 32'(!rst));
        if (armed) begin
            check("valid_out", 32'(valid_out), 32'(exp_v));
            check("frame_err", 32'(frame_err), 32'(exp_e));
            check("frame_count", 32'(frame_count), 32'(exp_cnt));
            bad = 0;
            for (int i = 0; i < LEN; i++) begin
                if (data_out[i] !== exp_out[i]) bad++;
            end
            check("data_out_bad_elems", 32'(bad), 32'd0);
        end
        if (valid_out === 1'b1) begin
            obs_s[prev_entry]++;
            strobe_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) obs_e[prev_entry]++;
        prev_entry = cur_entry;
        rst     = r;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        model_beat(r, v, d, l);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, DW'($urandom), 1'($urandom));
    endtask

    initial begin
        int bad;
        logic signed [DW-1:0] d;

        //            n    last pat       gaps idle rst  S  E
        vecs[0] = '{LEN, LEN-1, PAT_RAMP, 1'b0, 0, 1'b0, 1, 0};
        vecs[1] = '{LEN, LEN-1, PAT_FF,   1'b0, 2, 1'b0, 1, 0};
        vecs[2] = '{LEN, LEN-1, PAT_RAND, 1'b1, 2, 1'b0, 1, 0};
        vecs[3] = '{100, 99,    PAT_RAND, 1'b0, 2, 1'b0, 0, 1};
        vecs[4] = '{LEN, LEN-1, PAT_RAND, 1'b0, 2, 1'b0, 1, 0};
        vecs[5] = '{LEN+10, LEN+9, PAT_RAND, 1'b0, 2, 1'b0, 1, 1};
        vecs[6] = '{LEN, LEN-1, PAT_RAND, 1'b1, 2, 1'b0, 1, 0};
        vecs[7] = '{300, -1,    PAT_RAND, 1'b0, 2, 1'b1, 0, 0};
        vecs[8] = '{LEN, LEN-1, PAT_RAND, 1'b0, 2, 1'b0, 1, 0};

        for (int i = 0; i < 16; i++) begin
            obs_s[i] = 0;
            obs_e[i] = 0;
        end
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, DW'(8'h55), 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        for (int e = 0; e < NE; e++) begin
            cur_entry = e;
            for (int b = 0; b < vecs[e].n_beats; b++) begin
                if (vecs[e].gaps) begin
                    for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) idle();
                end
                case (vecs[e].pat)
                    PAT_RAMP: d = DW'(b % 128);
                    PAT_FF:   d = '1;
                    default:  d = DW'($urandom_range(0, 255));
                endcase
                if (b == 0) first_beat[e] = d;
                step(1'b0, 1'b1, d, b == vecs[e].last_at);
                if (e == 1 && b == 1) begin
                    bad = 0;
                    for (int i = 0; i < LEN; i++) begin
                        if (data_out[i] !== DW'(i % 128)) bad++;
                    end
                    check("ramp_map_bad_elems", 32'(bad), 32'd0);
                    check("ramp_frame_count", 32'(frame_count), 32'd1);
                end
            end
            if (vecs[e].rst_after) step(1'b1, 1'b0, '0, 1'b0);
            for (int k = 0; k < vecs[e].idle_after; k++) idle();

            case (e)
                1: begin
                    bad = 0;
                    for (int i = 0; i < LEN; i++) begin
                        if (data_out[i] !== DW'(8'hFF)) bad++;
                    end
                    check("ff_map_bad_elems", 32'(bad), 32'd0);
                    check("ff_frame_count", 32'(frame_count), 32'd2);
                    if (strobe_cyc.size() >= 2) begin
                        check("b2b_strobe_spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(LEN));
                    end else begin
                        check("b2b_strobe_seen", 32'(strobe_cyc.size()), 32'd2);
                    end
                end
                4: check("after_short_elem0", 32'(data_out[0]), 32'(first_beat[4]));
                6: check("after_long_elem0", 32'(data_out[0]), 32'(first_beat[6]));
                7: begin
                    check("midframe_rst_count", 32'(frame_count), 32'd0);
                    check("midframe_rst_elem0", 32'(data_out[0]), 32'd0);
                end
                8: begin
                    check("post_rst_count", 32'(frame_count), 32'd1);
                    check("post_rst_elem0", 32'(data_out[0]), 32'(first_beat[8]));
                end
                default: ;
            endcase
        end

        cur_entry = 15;
        idle();
        idle();

        for (int e = 0; e < NE; e++) begin
            check($sformatf("entry%0d_strobes", e), 32'(obs_s[e]), 32'(vecs[e].exp_strobes));
            check($sformatf("entry%0d_errs", e), 32'(obs_e[e]), 32'(vecs[e].exp_errs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
